// File: rtl/uart_rx_8n1_if.sv
// Receive-side bundle of the 8N1 UART.
//   rxd       serial line into the receiver (idle high)
//   rx_ready  one-cycle strobe: rdata holds a freshly received byte
//   rdata     last good byte, held until the next good byte
//   ferr      one-cycle strobe: stop bit sampled low
//   busy      receiver is somewhere inside a frame
// master: the receiver itself. slave: whatever feeds the line and consumes bytes.
interface uart_rx_8n1_if;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rdata;
  logic       ferr;
  logic       busy;

  modport master (input rxd, output rx_ready, output rdata, output ferr, output busy);
  modport slave  (output rxd, input rx_ready, input rdata, input ferr, input busy);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver (LSB first) feeding the program loader.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    uart_rx_8n1_if.master: rxd in; rx_ready, rdata, ferr, busy out
// A falling edge on the synchronised line starts a frame. The start bit is
// re-checked at its middle to reject glitches. Data and stop bits are sampled
// one bit period apart from there. A low stop bit raises ferr and parks the
// receiver until the line goes high again, so a held-low line yields a single
// ferr.
module uart_rx_8n1 #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic          clock,
  input  logic          reset,
  uart_rx_8n1_if.master bus
);

  localparam int HALF_BIT = CLK_PER_BIT / 2;
  localparam int CW       = $clog2(CLK_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  // Two-stage synchroniser. Both stages reset high so that reset never
  // looks like a start edge.
  logic sync1_q, sync2_q;
  logic rxd_s;
  assign rxd_s = sync2_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rx_ready_q, rx_ready_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            last_bit;

  // Terminal flag for the bit index: the sample now being taken is bit 7.
  assign last_bit = (bit_idx_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // Line back high by mid-start: treat as noise, no output.
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          if (last_bit) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          // Leaving at mid-stop lets a start bit that follows immediately
          // be caught on its leading edge.
          if (rxd_s) begin
            rdata_d    = shreg_q;
            rx_ready_d = 1'b1;
            state_d    = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= 8'h00;
      rdata_q    <= 8'h00;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= bus.rxd;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.rdata    = rdata_q;
  assign bus.ferr     = ferr_q;
  assign bus.busy     = busy_q;

endmodule
